// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock line, issues a
// request-to-send, shifts out 8 data bits + odd parity + stop, then checks the ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       KCLK,
  input  logic       KDAT,
  output logic       KCLK_OE,
  output logic       KDAT_OE,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned MAX_CYC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE} state_t;

  state_t         state, state_nx;
  logic [TW-1:0]  timer, timer_nx;
  logic [3:0]     n, n_nx;
  logic [7:0]     data_q, data_nx;
  logic           par_q, par_nx;
  logic           kclk_oe_nx, kdat_oe_nx, busy_nx, done_nx, err_nx;
  logic           kc1, kc2, kc3, kd1, kd2;
  logic           kclk_fall;

  // Pad synchronizers; kc3 is the previous synchronized clock for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kc1 <= 1'b1;
      kc2 <= 1'b1;
      kc3 <= 1'b1;
      kd1 <= 1'b1;
      kd2 <= 1'b1;
    end else begin
      kc1 <= KCLK;
      kc2 <= kc1;
      kc3 <= kc2;
      kd1 <= KDAT;
      kd2 <= kd1;
    end
  end

  assign kclk_fall = kc3 & ~kc2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      n       <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      KCLK_OE <= 1'b0;
      KDAT_OE <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      n       <= n_nx;
      data_q  <= data_nx;
      par_q   <= par_nx;
      KCLK_OE <= kclk_oe_nx;
      KDAT_OE <= kdat_oe_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      err     <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    n_nx       = n;
    data_nx    = data_q;
    par_nx     = par_q;
    kclk_oe_nx = KCLK_OE;
    kdat_oe_nx = KDAT_OE;
    done_nx    = 1'b0;
    err_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          data_nx    = tx_data;
          par_nx     = ~^tx_data;
          kclk_oe_nx = 1'b1;
          timer_nx   = '0;
          state_nx   = INHIBIT;
        end
      end
      INHIBIT: begin
        timer_nx = timer + TW'(1);
        if (timer == TW'(INHIBIT_CYC - 1)) begin
          kdat_oe_nx = 1'b1;
          state_nx   = REQ;
        end
      end
      REQ: begin
        kclk_oe_nx = 1'b0;
        timer_nx   = '0;
        n_nx       = '0;
        state_nx   = SEND;
      end
      SEND, ACK, WAITIDLE: begin
        timer_nx = timer + TW'(1);
        // Timeout overrides any line activity in the same cycle.
        if (timer == TW'(TIMEOUT_CYC - 1)) begin
          kclk_oe_nx = 1'b0;
          kdat_oe_nx = 1'b0;
          err_nx     = 1'b1;
          state_nx   = IDLE;
        end else if (state == SEND) begin
          if (kclk_fall) begin
            n_nx = n + 4'd1;
            if (n < 4'd8) begin
              kdat_oe_nx = ~data_q[n[2:0]];
            end else if (n == 4'd8) begin
              kdat_oe_nx = ~par_q;
            end else begin
              kdat_oe_nx = 1'b0;
              state_nx   = ACK;
            end
          end
        end else if (state == ACK) begin
          if (kclk_fall) begin
            if (!kd2) begin
              state_nx = WAITIDLE;
            end else begin
              err_nx   = 1'b1;
              state_nx = IDLE;
            end
          end
        end else begin
          if (kc2 && kd2) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural PS/2 device that
// clocks the frame, records the bits it reads and optionally ACKs.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 200;
  localparam int unsigned TMO  = 3000;
  localparam int          HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       KCLK_OE, KDAT_OE, busy, done, err;
  logic       dev_clk = 1'b0;
  logic       dev_dat = 1'b0;
  logic       kclk_line, kdat_line;

  assign kclk_line = ~(KCLK_OE | dev_clk);
  assign kdat_line = ~(KDAT_OE | dev_dat);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .KCLK(kclk_line), .KDAT(kdat_line),
    .KCLK_OE(KCLK_OE), .KDAT_OE(KDAT_OE), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Passive monitor of pulse outputs, sampled on the falling edge.
  int   cyc = 0, dn_cnt = 0, er_cnt = 0, both_cnt = 0, busy_bad = 0;
  int   t_rel = 0, t_err = 0;
  logic prev_kclk_oe = 1'b0;
  logic [1:0] oe_at_err = 2'b00;

  always @(negedge clk) begin
    cyc          <= cyc + 1;
    prev_kclk_oe <= KCLK_OE;
    if (prev_kclk_oe && !KCLK_OE) t_rel <= cyc;
    if (done) dn_cnt <= dn_cnt + 1;
    if (err) begin
      er_cnt    <= er_cnt + 1;
      t_err     <= cyc;
      oe_at_err <= {KCLK_OE, KDAT_OE};
    end
    if (done && err) both_cnt <= both_cnt + 1;
    if (done && busy) busy_bad <= busy_bad + 1;
  end

  // Pulses tx_start and returns the number of cycles KCLK was held low before KDAT dropped.
  task automatic start_tx(input logic [7:0] d, output int inh_cnt);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    inh_cnt  = 0;
    for (int i = 0; i < 4 * INH; i++) begin
      if (KDAT_OE) break;
      if (KCLK_OE) inh_cnt++;
      @(negedge clk);
    end
  endtask

  // Device: mode 0 ACKs, mode 1 leaves KDAT high in the ACK slot, mode 2 stops after bit 4.
  task automatic device(input int mode, output logic [10:0] bits, output bit seen);
    seen = 1'b0;
    bits = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (kclk_line && !kdat_line) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) return;
    for (int k = 1; k <= 11; k++) begin
      if (mode == 2 && k == 5) return;
      if (k == 11 && mode == 0) dev_dat = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      if (k <= 10) bits[k] = kdat_line;
    end
    dev_dat = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Reference frame: bit k (1..8) = data LSB first, 9 = odd parity, 10 = stop.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic [10:0] bits);
    logic exp_par;
    exp_par = ($countones(d) % 2 == 0);
    for (int k = 1; k <= 8; k++)
      check($sformatf("%s_bit%0d", tag, k - 1), 32'(bits[k]), 32'((d >> (k - 1)) & 8'h01));
    check({tag, "_parity"}, 32'(bits[9]), 32'(exp_par));
    check({tag, "_stop"}, 32'(bits[10]), 32'd1);
  endtask

  task automatic good_frame(input string tag, input logic [7:0] d);
    int         inh, d0, e0;
    logic [10:0] bits;
    bit          seen;
    d0 = dn_cnt;
    e0 = er_cnt;
    start_tx(d, inh);
    check({tag, "_inhibit"}, 32'(inh), 32'(INH));
    device(0, bits, seen);
    check({tag, "_req_seen"}, 32'(seen), 32'd1);
    wait_idle(500);
    check_frame(tag, d, bits);
    check({tag, "_done"}, 32'(dn_cnt - d0), 32'd1);
    check({tag, "_err"}, 32'(er_cnt - e0), 32'd0);
  endtask

  initial begin
    int          inh, d0, e0;
    logic [10:0] bits;
    bit          seen;

    repeat (3) @(negedge clk);
    check("rst_kclk_oe", 32'(KCLK_OE), 32'd0);
    check("rst_kdat_oe", 32'(KDAT_OE), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    good_frame("ed", 8'hED);
    good_frame("f4", 8'hF4);
    for (int r = 0; r < 3; r++) good_frame($sformatf("rnd%0d", r), 8'($urandom));

    // Missing ACK.
    d0 = dn_cnt;
    e0 = er_cnt;
    start_tx(8'h5A, inh);
    device(1, bits, seen);
    wait_idle(500);
    check("nack_err", 32'(er_cnt - e0), 32'd1);
    check("nack_done", 32'(dn_cnt - d0), 32'd0);
    check("nack_busy", 32'(busy), 32'd0);

    // Device stalls after the 4th bit.
    d0 = dn_cnt;
    e0 = er_cnt;
    start_tx(8'h3C, inh);
    device(2, bits, seen);
    wait_idle(TMO + 500);
    check("tmo_err", 32'(er_cnt - e0), 32'd1);
    check("tmo_done", 32'(dn_cnt - d0), 32'd0);
    check("tmo_latency", 32'(t_err - t_rel), 32'(TMO));
    check("tmo_oe", 32'(oe_at_err), 32'd0);

    // Second tx_start while the frame is being shifted.
    d0 = dn_cnt;
    e0 = er_cnt;
    start_tx(8'hA7, inh);
    fork
      device(0, bits, seen);
      begin
        repeat (300) @(negedge clk);
        tx_data  = 8'h18;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    wait_idle(500);
    check_frame("busy_start", 8'hA7, bits);
    check("busy_start_done", 32'(dn_cnt - d0), 32'd1);
    repeat (INH + 50) @(negedge clk);
    check("busy_start_no_retx", 32'(KCLK_OE), 32'd0);

    // Reset in the middle of INHIBIT.
    d0 = dn_cnt;
    e0 = er_cnt;
    @(negedge clk);
    tx_data  = 8'h99;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_rst_kclk_oe", 32'(KCLK_OE), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_kclk_oe", 32'(KCLK_OE), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (INH + 100) @(negedge clk);
    check("post_rst_done", 32'(dn_cnt - d0), 32'd0);
    check("post_rst_err", 32'(er_cnt - e0), 32'd0);
    good_frame("after_rst", 8'hED);

    check("done_err_overlap", 32'(both_cnt), 32'd0);
    check("busy_with_done", 32'(busy_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
